// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode encodings and data width for the 8-bit CPU
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;
    localparam logic [OP_W-1:0] OP_DIV = 3'b110;
    localparam logic [OP_W-1:0] OP_CMP = 3'b111;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational unsigned ALU with carry/flag output
//
// Ports:
//   a, b   : 8-bit unsigned operands
//   sel    : ALU select (cpu_pkg OP_* encoding)
//   y      : 8-bit result
//   carry  : carry / borrow / overflow / divide-error flag for the result
module alu_core
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   sel,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;

    // Ninth bit of the zero-extended difference is the borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    // Divider is fed a safe divisor when b is zero; the result is overridden below.
    assign quot = a / ((b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b);

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (sel)
            OP_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                y     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_MUL: begin
                y     = prod[DATA_W-1:0];
                carry = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                if (b == '0) begin
                    y     = '1;
                    carry = 1'b1;
                end else begin
                    y = quot;
                end
            end
            OP_CMP: y = {5'b0, (a > b), (a == b), (a < b)};
            default: begin
                y     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - opcode decode, ALU and stored result register
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset (clears data_out only)
//   a, b      : 8-bit operands
//   opcode    : 3-bit operation code
//   alu_sel   : decoded ALU select (combinational)
//   alu_out   : ALU result (combinational)
//   carry_out : flag for the current result (combinational)
//   save      : store enable for data_out
//   data_out  : registered stored result
module instruction_memory
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [OP_W-1:0]   alu_sel,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry_out,
    input  logic              save,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Opcodes map one-to-one onto ALU selects.
    assign alu_sel = opcode;

    alu_core u_alu_core (
        .a     (a),
        .b     (b),
        .sel   (alu_sel),
        .y     (alu_out),
        .carry (carry_out)
    );

    always_comb begin
        data_d = data_q;
        if (save) begin
            data_d = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed self-checking bench for instruction_memory
module tb_instruction_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       save;
    logic [7:0] data_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_q = 8'h00;
    logic [7:0] sb_q[$];

    instruction_memory dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .save      (save),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one step, check combinational outputs, then check data_out after the edge
    task automatic apply(input string tag, input logic [2:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input logic sv, input logic rv,
                         input logic [7:0] exp_alu, input logic exp_c);
        logic [7:0] exp_data;
        @(negedge clk);
        opcode = op;
        a      = av;
        b      = bv;
        save   = sv;
        reset  = rv;
        #1;
        check8({tag, ".alu_out"}, alu_out, exp_alu);
        check1({tag, ".carry_out"}, carry_out, exp_c);
        if (rv)      model_q = 8'h00;
        else if (sv) model_q = exp_alu;
        sb_q.push_back(model_q);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.scoreboard: observed empty queue expected entry", tag);
        end else begin
            exp_data = sb_q.pop_front();
            check8({tag, ".data_out"}, data_out, exp_data);
        end
    endtask

    initial begin
        reset  = 1'b1;
        save   = 1'b1;
        a      = 8'h00;
        b      = 8'h00;
        opcode = 3'b000;

        apply("rst0",     3'b000, 8'h05, 8'h03, 1'b1, 1'b1, 8'h08, 1'b0);
        apply("rst1",     3'b000, 8'h05, 8'h03, 1'b1, 1'b1, 8'h08, 1'b0);
        apply("add_nosv", 3'b000, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0);
        apply("sub_sv",   3'b001, 8'hCC, 8'hAA, 1'b1, 1'b0, 8'h22, 1'b0);
        apply("sub_brw",  3'b001, 8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1);
        apply("and",      3'b010, 8'h05, 8'h03, 1'b1, 1'b0, 8'h01, 1'b0);
        apply("or",       3'b011, 8'hCC, 8'hAA, 1'b1, 1'b0, 8'hEE, 1'b0);
        apply("xor",      3'b100, 8'h05, 8'h03, 1'b1, 1'b0, 8'h06, 1'b0);
        apply("mul_ovf",  3'b101, 8'hCC, 8'hAA, 1'b1, 1'b0, 8'h78, 1'b1);
        apply("mul_sm",   3'b101, 8'h05, 8'h03, 1'b0, 1'b0, 8'h0F, 1'b0);
        apply("div",      3'b110, 8'h05, 8'h03, 1'b1, 1'b0, 8'h01, 1'b0);
        apply("div0",     3'b110, 8'h05, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);
        apply("cmp_gt",   3'b111, 8'hCC, 8'hAA, 1'b1, 1'b0, 8'h04, 1'b0);
        apply("cmp_eq",   3'b111, 8'h05, 8'h05, 1'b0, 1'b0, 8'h02, 1'b0);
        apply("cmp_lt",   3'b111, 8'h03, 8'h05, 1'b1, 1'b0, 8'h01, 1'b0);
        apply("rst_sv",   3'b000, 8'h05, 8'h03, 1'b1, 1'b1, 8'h08, 1'b0);
        apply("add_cy",   3'b000, 8'hFF, 8'h02, 1'b1, 1'b0, 8'h01, 1'b1);
        apply("sub_eq",   3'b001, 8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0);
        apply("div_big",  3'b110, 8'hFF, 8'h10, 1'b1, 1'b0, 8'h0F, 1'b0);
        apply("add_rst2", 3'b000, 8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] op_v;
            op_v = 3'(i);
            @(negedge clk);
            opcode = op_v;
            save   = 1'b0;
            reset  = 1'b0;
            #1;
            vectors++;
            assert (alu_sel === op_v) else begin
                miscompares++;
                $error("FAIL alu_sel[%0d]: observed %b expected %b", i, alu_sel, op_v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
